// File: rtl/manual_pkg.sv
// Shared encodings for the manual-mode driving controller: FSM states, moving
// directions, power levels and turn-light patterns.
package manual_pkg;

  typedef enum logic [1:0] {
    NSTART = 2'b00,
    START  = 2'b01,
    MOVING = 2'b10
  } state_t;

  typedef enum logic [3:0] {
    NON_MOVING   = 4'b0000,
    MOVE_FORWARD = 4'b0001,
    MOVE_BACK    = 4'b0010,
    TURN_LEFT    = 4'b0100,
    TURN_RIGHT   = 4'b1000
  } move_t;

  typedef enum logic {
    POFF = 1'b0,
    PON  = 1'b1
  } power_t;

  typedef enum logic [2:0] {
    PAT_OFF,
    PAT_STEADY,
    PAT_LEFT,
    PAT_RIGHT,
    PAT_HAZARD
  } light_pat_t;

  // Both or neither turn request means straight ahead.
  function automatic move_t dir_rule(input logic left, input logic right);
    if (left && !right)      return TURN_LEFT;
    else if (right && !left) return TURN_RIGHT;
    else                     return MOVE_FORWARD;
  endfunction

  function automatic logic [2:0] state_onehot(input state_t s);
    case (s)
      NSTART:  return 3'b001;
      START:   return 3'b010;
      MOVING:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Turn-light blink generator: phase toggles every BLINK_DIV cycles; restart
// returns to count 0 with the phase lit so a new pattern starts visible.
module blink_gen #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Clocked manual-mode driving controller: NSTART/START/MOVING FSM, direction,
// stall pulse, turn/state lights. Define MANUAL_MILEAGE_EN for the mileage counter.
module manual_drive_ctrl
  import manual_pkg::*;
#(
  parameter int BLINK_DIV = 50_000_000,
  parameter int TICK_DIV  = 100_000_000,
  parameter int MILE_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              clutch,
  input  logic              brake,
  input  logic              throttle,
  input  logic              rgs,
  input  logic              left,
  input  logic              right,
  output logic [1:0]        state,
  output logic [3:0]        moving_state,
  output logic              stall,
  output logic              turn_left_light,
  output logic              turn_right_light,
  output logic [2:0]        state_light,
  output logic [3:0]        moving_light,
  output logic [MILE_W-1:0] mileage
);

  if (BLINK_DIV < 2 || TICK_DIV < 2) begin : g_param_check
    $error("manual_drive_ctrl: BLINK_DIV and TICK_DIV must be >= 2");
  end

  state_t     state_q, state_n;
  move_t      move_q, move_n;
  power_t     pwr_q;
  light_pat_t pat_q, pat_n;
  logic       stall_n;
  logic       phase;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    move_n  = move_q;
    stall_n = 1'b0;
    if (!power) begin
      state_n = NSTART;
      move_n  = NON_MOVING;
    end else begin
      case (state_q)
        NSTART: begin
          move_n = NON_MOVING;
          if (brake)                          state_n = NSTART;
          else if (throttle && !clutch)       stall_n = 1'b1;
          else if (throttle && clutch && !rgs) state_n = START;
        end
        START: begin
          if (brake) begin
            state_n = NSTART;
            move_n  = NON_MOVING;
          end else if (throttle && !clutch) begin
            state_n = MOVING;
            move_n  = rgs ? MOVE_BACK : dir_rule(left, right);
          end else begin
            move_n  = NON_MOVING;
          end
        end
        MOVING: begin
          // The reverse-gear stall outranks brake.
          if (rgs && !clutch) begin
            stall_n = 1'b1;
            state_n = NSTART;
            move_n  = NON_MOVING;
          end else if (brake) begin
            state_n = NSTART;
            move_n  = NON_MOVING;
          end else if (!throttle) begin
            state_n = START;
            move_n  = NON_MOVING;
          end else if (rgs) begin
            move_n  = MOVE_BACK;
          end else begin
            move_n  = dir_rule(left, right);
          end
        end
        default: begin
          state_n = NSTART;
          move_n  = NON_MOVING;
        end
      endcase
    end
  end

  always_comb begin
    pat_n = PAT_OFF;
    if (power) begin
      case (state_n)
        NSTART: pat_n = PAT_STEADY;
        MOVING: begin
          case (move_n)
            TURN_LEFT:    pat_n = PAT_LEFT;
            TURN_RIGHT:   pat_n = PAT_RIGHT;
            MOVE_FORWARD: pat_n = (left && right) ? PAT_HAZARD : PAT_OFF;
            default:      pat_n = PAT_OFF;
          endcase
        end
        default: pat_n = PAT_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NSTART;
      move_q  <= NON_MOVING;
      pwr_q   <= POFF;
      pat_q   <= PAT_OFF;
      stall   <= 1'b0;
    end else begin
      state_q <= state_n;
      move_q  <= move_n;
      pwr_q   <= power ? PON : POFF;
      pat_q   <= pat_n;
      stall   <= stall_n;
    end
  end

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (pat_n != pat_q),
    .phase   (phase)
  );

  always_comb begin
    turn_left_light  = 1'b0;
    turn_right_light = 1'b0;
    case (pat_q)
      PAT_STEADY: begin
        turn_left_light  = 1'b1;
        turn_right_light = 1'b1;
      end
      PAT_LEFT:   turn_left_light = phase;
      PAT_RIGHT:  turn_right_light = phase;
      PAT_HAZARD: begin
        turn_left_light  = phase;
        turn_right_light = phase;
      end
      default: ;
    endcase
  end

  assign state        = state_q;
  assign moving_state = move_q;
  assign state_light  = (pwr_q == PON) ? state_onehot(state_q) : 3'b000;
  assign moving_light = (pwr_q == PON) ? move_q : NON_MOVING;

`ifdef MANUAL_MILEAGE_EN
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      mileage  <= '0;
    end else if (state_q == MOVING && move_q != NON_MOVING) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        if (mileage != '1) mileage <= mileage + MILE_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end
`else
  assign mileage = '0;
`endif

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl: expected snapshots are queued as each
// step is driven and compared after the following clock edge.
module tb_manual_drive_ctrl;

  localparam int BLINK_DIV = 4;
  localparam int TICK_DIV  = 3;
  localparam int MILE_W    = 2;

  logic clk = 1'b0;
  logic rst;
  logic power, clutch, brake, throttle, rgs, left, right;
  logic [1:0]        state;
  logic [3:0]        moving_state;
  logic              stall;
  logic              turn_left_light, turn_right_light;
  logic [2:0]        state_light;
  logic [3:0]        moving_light;
  logic [MILE_W-1:0] mileage;

  manual_drive_ctrl #(
    .BLINK_DIV (BLINK_DIV),
    .TICK_DIV  (TICK_DIV),
    .MILE_W    (MILE_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .power            (power),
    .clutch           (clutch),
    .brake            (brake),
    .throttle         (throttle),
    .rgs              (rgs),
    .left             (left),
    .right            (right),
    .state            (state),
    .moving_state     (moving_state),
    .stall            (stall),
    .turn_left_light  (turn_left_light),
    .turn_right_light (turn_right_light),
    .state_light      (state_light),
    .moving_light     (moving_light),
    .mileage          (mileage)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic [1:0]        st;
    logic [3:0]        mv;
    logic              stl;
    logic              tl;
    logic              tr;
    logic [2:0]        sl;
    logic [3:0]        ml;
    logic [MILE_W-1:0] mile;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [MILE_W-1:0] m_mile = '0;

`ifdef MANUAL_MILEAGE_EN
  int         m_tick = 0;
  logic [1:0] prev_st = 2'b00;
  logic [3:0] prev_mv = 4'b0000;
`endif

  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at step %0d", step_no);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".state"},        32'(state),            32'(e.st));
    check({e.tag, ".moving_state"}, 32'(moving_state),     32'(e.mv));
    check({e.tag, ".stall"},        32'(stall),            32'(e.stl));
    check({e.tag, ".left_light"},   32'(turn_left_light),  32'(e.tl));
    check({e.tag, ".right_light"},  32'(turn_right_light), 32'(e.tr));
    check({e.tag, ".state_light"},  32'(state_light),      32'(e.sl));
    check({e.tag, ".moving_light"}, 32'(moving_light),     32'(e.ml));
    check({e.tag, ".mileage"},      32'(mileage),          32'(e.mile));
  endtask

  // in = {power, clutch, brake, throttle, rgs, left, right}
  task automatic step(input logic [6:0] in, input logic [1:0] st, input logic [3:0] mv,
                      input logic stl, input logic tl, input logic tr);
    exp_t e;
    step_no++;
    {power, clutch, brake, throttle, rgs, left, right} = in;
`ifdef MANUAL_MILEAGE_EN
    // One tick per cycle spent moving before this edge.
    if (prev_st == 2'b10 && prev_mv != 4'b0000) begin
      if (m_tick == TICK_DIV - 1) begin
        m_tick = 0;
        if (m_mile != '1) m_mile = m_mile + 1'b1;
      end else begin
        m_tick++;
      end
    end
    prev_st = st;
    prev_mv = mv;
`endif
    e.tag  = $sformatf("s%0d", step_no);
    e.st   = st;
    e.mv   = mv;
    e.stl  = stl;
    e.tl   = tl;
    e.tr   = tr;
    e.sl   = power ? onehot(st) : 3'b000;
    e.ml   = power ? mv : 4'b0000;
    e.mile = m_mile;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic expect_reset(input string tag);
    exp_t e;
    m_mile = '0;
`ifdef MANUAL_MILEAGE_EN
    m_tick  = 0;
    prev_st = 2'b00;
    prev_mv = 4'b0000;
`endif
    e.tag = tag; e.st = 2'b00; e.mv = 4'b0000; e.stl = 1'b0; e.tl = 1'b0;
    e.tr = 1'b0; e.sl = 3'b000; e.ml = 4'b0000; e.mile = '0;
    sb.push_back(e);
    compare_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at step %0d", step_no);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    {power, clutch, brake, throttle, rgs, left, right} = 7'b0;
    #12;
    expect_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    step(7'b1000000, 2'b00, 4'b0000, 0, 1, 1);  // powered NSTART: steady lights
    step(7'b1001000, 2'b00, 4'b0000, 1, 1, 1);  // throttle without clutch: stall
    step(7'b1000000, 2'b00, 4'b0000, 0, 1, 1);  // pulse lasts one cycle
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);  // clutch+throttle: START
    step(7'b1001000, 2'b10, 4'b0001, 0, 0, 0);  // release clutch: MOVING forward
    // Left blink: 4 lit, 4 dark, lit again.
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001001, 2'b10, 4'b1000, 0, 0, 1);  // right turn restarts lit
    step(7'b1001011, 2'b10, 4'b0001, 0, 1, 1);  // both: forward with hazard
    step(7'b1001011, 2'b10, 4'b0001, 0, 1, 1);
    step(7'b1001000, 2'b10, 4'b0001, 0, 0, 0);
    step(7'b1000000, 2'b01, 4'b0000, 0, 0, 0);  // throttle off: START
    step(7'b1001000, 2'b10, 4'b0001, 0, 0, 0);
    step(7'b1011100, 2'b00, 4'b0000, 1, 1, 1);  // reverse stall beats brake
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);
    step(7'b1001000, 2'b10, 4'b0001, 0, 0, 0);
    step(7'b1101100, 2'b10, 4'b0010, 0, 0, 0);  // reverse with clutch: back
    step(7'b1101100, 2'b10, 4'b0010, 0, 0, 0);
    step(7'b1011000, 2'b00, 4'b0000, 0, 1, 1);  // brake while moving
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b0001010, 2'b00, 4'b0000, 0, 0, 0);  // power drop mid-move
    step(7'b1000000, 2'b00, 4'b0000, 0, 1, 1);
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);
    step(7'b1001010, 2'b10, 4'b0100, 0, 1, 0);

    // Asynchronous reset between clock edges, mid-blink.
    #2;
    rst = 1'b1;
    #1;
    expect_reset("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(7'b1000000, 2'b00, 4'b0000, 0, 1, 1);
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);
    step(7'b1111000, 2'b00, 4'b0000, 0, 1, 1);  // brake in START
    step(7'b1101100, 2'b00, 4'b0000, 0, 1, 1);  // reverse gear blocks start
    step(7'b1101000, 2'b01, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 13; i++) step(7'b1001000, 2'b10, 4'b0001, 0, 0, 0);
    step(7'b1000000, 2'b01, 4'b0000, 0, 0, 0);  // mileage frozen in START
    step(7'b1000000, 2'b01, 4'b0000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
